// File: rtl/ppu_misc_ctrl.sv
// ppu_misc_ctrl: PPU miscellaneous control pins.
// Single-beat command interface writing a MODE register, plus timed pulses on
// the PPU1 external sync (active low) and PPU2 external latch pins.
// Optional feature macro: MISC_CTRL_PERIODIC_LATCH_EN adds a PERIOD register
// (addr 3) that ORs a periodic one-cycle latch pulse onto ppu2_extlatch.
module ppu_misc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       ppu1_extsync_n,
  output logic       ppu1_hvcmode,
  output logic       ppu1_master_n,
  output logic       ppu1_palmode,
  output logic       ppu2_extlatch,
  output logic       ppu2_hvcmode,
  output logic       ppu2_palmode
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SYNC_PULSE  = 2'd1,
    LATCH_PULSE = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_MODE  = 3'd0;
  localparam logic [2:0] ADDR_SYNC  = 3'd1;
  localparam logic [2:0] ADDR_LATCH = 3'd2;

  state_t     state;
  logic [7:0] pulse_cnt;
  logic       latch_q;
  logic       cmd_fire;

  // Commands are only taken while idle; busy is simply the complement.
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Control FSM: MODE register writes and the down-counted sync/latch pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pulse_cnt      <= 8'd0;
      ppu1_extsync_n <= 1'b1;
      ppu1_hvcmode   <= 1'b0;
      ppu1_palmode   <= 1'b0;
      ppu1_master_n  <= 1'b0;
      ppu2_hvcmode   <= 1'b0;
      ppu2_palmode   <= 1'b0;
      latch_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_addr)
              ADDR_MODE: begin
                ppu1_hvcmode  <= cmd_data[0];
                ppu1_palmode  <= cmd_data[1];
                ppu1_master_n <= cmd_data[2];
                ppu2_hvcmode  <= cmd_data[3];
                ppu2_palmode  <= cmd_data[4];
              end
              ADDR_SYNC: begin
                if (cmd_data != 8'd0) begin
                  state          <= SYNC_PULSE;
                  pulse_cnt      <= cmd_data;
                  ppu1_extsync_n <= 1'b0;
                end
              end
              ADDR_LATCH: begin
                if (cmd_data != 8'd0) begin
                  state     <= LATCH_PULSE;
                  pulse_cnt <= cmd_data;
                  latch_q   <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
        end
        SYNC_PULSE: begin
          if (pulse_cnt == 8'd1) begin
            state          <= IDLE;
            pulse_cnt      <= 8'd0;
            ppu1_extsync_n <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end
        LATCH_PULSE: begin
          if (pulse_cnt == 8'd1) begin
            state     <= IDLE;
            pulse_cnt <= 8'd0;
            latch_q   <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MISC_CTRL_PERIODIC_LATCH_EN
  localparam logic [2:0] ADDR_PERIOD = 3'd3;

  logic [7:0] period_reg;
  logic [7:0] period_cnt;
  logic       periodic_hit;

  // Free-running period counter; counts cycles remaining until the next pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_reg <= 8'd0;
      period_cnt <= 8'd0;
    end else if (cmd_fire && (cmd_addr == ADDR_PERIOD)) begin
      period_reg <= cmd_data;
      period_cnt <= cmd_data - 8'd1;
    end else if (period_reg != 8'd0) begin
      period_cnt <= (period_cnt == 8'd0) ? (period_reg - 8'd1) : (period_cnt - 8'd1);
    end
  end

  assign periodic_hit  = (period_reg != 8'd0) && (period_cnt == 8'd0);
  assign ppu2_extlatch = latch_q | periodic_hit;
`else
  assign ppu2_extlatch = latch_q;
`endif

endmodule

// File: tb/tb_ppu_misc_ctrl.sv
// Self-checking bench for ppu_misc_ctrl: randomized and directed command
// sequences compared against a cycle-indexed model of the pin behaviour.
module tb_ppu_misc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       ppu1_extsync_n;
  logic       ppu1_hvcmode;
  logic       ppu1_master_n;
  logic       ppu1_palmode;
  logic       ppu2_extlatch;
  logic       ppu2_hvcmode;
  logic       ppu2_palmode;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_mode;
  logic [4:0] mode_pins;

  ppu_misc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .busy           (busy),
    .ppu1_extsync_n (ppu1_extsync_n),
    .ppu1_hvcmode   (ppu1_hvcmode),
    .ppu1_master_n  (ppu1_master_n),
    .ppu1_palmode   (ppu1_palmode),
    .ppu2_extlatch  (ppu2_extlatch),
    .ppu2_hvcmode   (ppu2_hvcmode),
    .ppu2_palmode   (ppu2_palmode)
  );

  // Mode pins gathered in MODE register bit order for comparison.
  assign mode_pins = {ppu2_palmode, ppu2_hvcmode, ppu1_master_n, ppu1_palmode, ppu1_hvcmode};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 3'd1;
    cmd_data  = 8'd5;
    step();
    step();
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    exp_mode  = 5'd0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ppu1_extsync_n !== 1'b1 || ppu2_extlatch !== 1'b0 || mode_pins !== exp_mode) begin
        errors++;
        $display("[TB] FAIL reset_pins: extsync_n=%b extlatch=%b mode=%b, expected 1 0 %b", ppu1_extsync_n, ppu2_extlatch, mode_pins, exp_mode);
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: ready=%b busy=%b, expected 1 0", cmd_ready, busy);
      end
      step();
    end
  endtask

  task automatic test_mode();
    logic [7:0] vals [$];
    vals.push_back(8'h1F);
    vals.push_back(8'h04);
    for (int i = 0; i < 6; i++) vals.push_back(8'($urandom));
    vals.push_back(8'h04);
    foreach (vals[i]) begin
      cmd_valid = 1'b1;
      cmd_addr  = 3'd0;
      cmd_data  = vals[i];
      step();
      cmd_valid = 1'b0;
      exp_mode  = vals[i][4:0];
      checks++;
      if (mode_pins !== exp_mode || ppu1_extsync_n !== 1'b1 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mode_write data=%h: mode=%b sync_n=%b ready=%b, expected %b 1 1", vals[i], mode_pins, ppu1_extsync_n, cmd_ready, exp_mode);
      end
    end
  endtask

  task automatic test_sync_held_valid();
    cmd_valid = 1'b1;
    cmd_addr  = 3'd1;
    cmd_data  = 8'd3;
    step();
    cmd_addr = 3'd0;
    cmd_data = 8'h1F;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (ppu1_extsync_n !== (k > 3) || cmd_ready !== (k > 3) || busy !== (k <= 3)) begin
        errors++;
        $display("[TB] FAIL sync3 k=%0d: sync_n=%b ready=%b busy=%b, expected %b %b %b", k, ppu1_extsync_n, cmd_ready, busy, k > 3, k > 3, k <= 3);
      end
      checks++;
      if (mode_pins !== exp_mode) begin
        errors++;
        $display("[TB] FAIL sync3_mode_hold k=%0d: mode=%b, expected %b", k, mode_pins, exp_mode);
      end
      step();
    end
    cmd_valid = 1'b0;
    exp_mode  = 5'h1F;
    checks++;
    if (mode_pins !== exp_mode) begin
      errors++;
      $display("[TB] FAIL sync3_held_accept: mode=%b, expected %b", mode_pins, exp_mode);
    end
  endtask

  task automatic test_random_cmds();
    logic [2:0] choices [$];
    logic [2:0] a;
    logic [7:0] n;
    logic       pulse;
    choices = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
`ifndef MISC_CTRL_PERIODIC_LATCH_EN
    choices.push_back(3'd3);
`endif
    for (int it = 0; it < 16; it++) begin
      a = choices[$urandom_range(0, choices.size() - 1)];
      n = (a == 3'd1 || a == 3'd2) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      pulse = (a == 3'd1 || a == 3'd2) && (n != 8'd0);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = n;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k <= int'(n) + 1; k++) begin
        if (!pulse && k > 1) break;
        checks++;
        if (ppu1_extsync_n !== !(a == 3'd1 && k <= int'(n)) ||
            ppu2_extlatch  !== (a == 3'd2 && k <= int'(n)) ||
            cmd_ready      !== !(pulse && k <= int'(n)) ||
            mode_pins      !== exp_mode) begin
          errors++;
          $display("[TB] FAIL rand_cmd addr=%0d n=%0d k=%0d: sync_n=%b latch=%b ready=%b mode=%b, expected %b %b %b %b",
                   a, n, k, ppu1_extsync_n, ppu2_extlatch, cmd_ready, mode_pins,
                   !(a == 3'd1 && k <= int'(n)), (a == 3'd2 && k <= int'(n)), !(pulse && k <= int'(n)), exp_mode);
        end
        step();
      end
    end
  endtask

  task automatic test_latch();
    int high_cycles = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 3'd2;
    cmd_data  = 8'd0;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ppu2_extlatch !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL latch0 k=%0d: latch=%b ready=%b, expected 0 1", k, ppu2_extlatch, cmd_ready);
      end
      step();
    end
    cmd_valid = 1'b1;
    cmd_data  = 8'd255;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      if (ppu2_extlatch === 1'b1) high_cycles++;
      checks++;
      if (ppu2_extlatch !== (k <= 255) || cmd_ready !== (k > 255)) begin
        errors++;
        $display("[TB] FAIL latch255 k=%0d: latch=%b ready=%b, expected %b %b", k, ppu2_extlatch, cmd_ready, k <= 255, k > 255);
      end
      step();
    end
    checks++;
    if (high_cycles != 255) begin
      errors++;
      $display("[TB] FAIL latch255_len: high for %0d cycles, expected 255", high_cycles);
    end
  endtask

  task automatic test_reset_mid_pulse();
    cmd_valid = 1'b1;
    cmd_addr  = 3'd1;
    cmd_data  = 8'd10;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (ppu1_extsync_n !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_before: sync_n=%b ready=%b, expected 0 0", ppu1_extsync_n, cmd_ready);
    end
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    exp_mode = 5'd0;
    checks++;
    if (ppu1_extsync_n !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || mode_pins !== exp_mode) begin
      errors++;
      $display("[TB] FAIL midreset_after: sync_n=%b ready=%b busy=%b mode=%b, expected 1 1 0 %b", ppu1_extsync_n, cmd_ready, busy, mode_pins, exp_mode);
    end
  endtask

  task automatic test_period();
    cmd_valid = 1'b1;
    cmd_addr  = 3'd3;
    cmd_data  = 8'd4;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
`ifdef MISC_CTRL_PERIODIC_LATCH_EN
      checks++;
      if (ppu2_extlatch !== (k % 4 == 0) || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL period4 k=%0d: latch=%b ready=%b, expected %b 1", k, ppu2_extlatch, cmd_ready, k % 4 == 0);
      end
`else
      checks++;
      if (ppu2_extlatch !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL period_absent k=%0d: latch=%b ready=%b, expected 0 1", k, ppu2_extlatch, cmd_ready);
      end
`endif
      if (k < 14) step();
    end
`ifdef MISC_CTRL_PERIODIC_LATCH_EN
    cmd_valid = 1'b1;
    cmd_data  = 8'd0;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (ppu2_extlatch !== 1'b0) begin
        errors++;
        $display("[TB] FAIL period0 k=%0d: latch=%b, expected 0", k, ppu2_extlatch);
      end
      step();
    end
    cmd_valid = 1'b1;
    cmd_data  = 8'd1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (ppu2_extlatch !== 1'b1 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL period1 k=%0d: latch=%b ready=%b, expected 1 1", k, ppu2_extlatch, cmd_ready);
      end
      if (k < 5) step();
    end
    cmd_valid = 1'b1;
    cmd_data  = 8'd0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (ppu2_extlatch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL period1_stop: latch=%b, expected 0", ppu2_extlatch);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 3'd0;
    cmd_data  = 8'd0;
    exp_mode  = 5'd0;
    test_reset();
    test_mode();
    test_sync_held_valid();
    test_random_cmds();
    test_latch();
    test_reset_mid_pulse();
    test_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
